// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg
//   Shared definitions for the polyphase FIR MAC sequencer: FSM state
//   encodings, the state enum built on them, and a helper that renders
//   a state as fixed-width ASCII for debug displays.
package ctrl_seq_pkg;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_CALC_ENC  = 3'd1;
  localparam logic [2:0] ST_LOAD_ENC  = 3'd2;
  localparam logic [2:0] ST_RUN_ENC   = 3'd3;
  localparam logic [2:0] ST_DRAIN_ENC = 3'd4;
  localparam logic [2:0] ST_OUT_ENC   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_CALC  = ST_CALC_ENC,
    S_LOAD  = ST_LOAD_ENC,
    S_RUN   = ST_RUN_ENC,
    S_DRAIN = ST_DRAIN_ENC,
    S_OUT   = ST_OUT_ENC
  } state_t;

  // Five characters per state name, eight bits each.
  localparam int STATE_NAME_W = 5 * 8;

  function automatic logic [STATE_NAME_W-1:0] state_name(input state_t s);
    case (s)
      S_IDLE:  state_name = "IDLE ";
      S_CALC:  state_name = "CALC ";
      S_LOAD:  state_name = "LOAD ";
      S_RUN:   state_name = "RUN  ";
      S_DRAIN: state_name = "DRAIN";
      S_OUT:   state_name = "OUT  ";
      default: state_name = "?????";
    endcase
  endfunction

endpackage

// File: rtl/ctrl_seq_tapcnt.sv
// ctrl_seq_tapcnt
//   Tap down-counter for one output sample. Loaded with the tap count,
//   decremented once per accumulate cycle.
// Ports
//   clk   in  clock, posedge
//   clr   in  synchronous active-high reset
//   load  in  load counter from taps
//   dec   in  decrement counter (ignored at zero)
//   taps  in  tap count to load
//   last  out registered flag, high exactly while count == 1
module ctrl_seq_tapcnt #(
  parameter int TAPS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  dec,
  input  logic [TAPS_WIDTH-1:0] taps,
  output logic                  last
);

  logic [TAPS_WIDTH-1:0] count;

  // last is computed one edge ahead so it is a clean flop output that
  // tracks count == 1 without a comparator on the output path.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values and simulation matches the netlist.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
      last  <= 1'b0;
    end else if (load) begin
      count <= taps;
      last  <= (taps == TAPS_WIDTH'(1));
    end else if (dec && (count != '0)) begin
      count <= count - TAPS_WIDTH'(1);
      last  <= (count == TAPS_WIDTH'(2));
    end
  end

endmodule

// File: rtl/ctrl_mac_sequencer.sv
// ctrl_mac_sequencer
//   Per-output-sample sequencer for the polyphase FIR datapath. Accepts a
//   phase index, computes the coefficient base pointer, drives load/count
//   strobes for the coefficient and data-ring address counters, sequences
//   MAC clear/enable, and presents the result with a valid/ready handshake.
// Ports
//   clk, clr                     clock and synchronous active-high reset
//   phase_valid/phase_ready      request handshake, phase_idx with it
//   coef_base, taps_per_phase    configuration, latched at accept
//   coef_ptr                     coef_base + phase_idx*taps (mod 2^DAW)
//   coef_load/coef_cnt           coefficient address counter control
//   data_load/data_cnt           data-ring address counter control
//   mac_clr/mac_en/mac_last      accumulator control
//   res_valid/res_ready          result handshake to the output stage
//   busy                         sequencer not idle
// Optional build macro CTRL_SEQ_STATS_EN adds stat_samples and stat_stalls.
module ctrl_mac_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int TAPS_WIDTH         = 8,
  parameter int PHASE_WIDTH        = 5,
  parameter int MAC_LATENCY        = 2
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          phase_valid,
  output logic                          phase_ready,
  input  logic [PHASE_WIDTH-1:0]        phase_idx,
  input  logic [DATA_ADDRESS_WIDTH-1:0] coef_base,
  input  logic [TAPS_WIDTH-1:0]         taps_per_phase,
  output logic [DATA_ADDRESS_WIDTH-1:0] coef_ptr,
  output logic                          coef_load,
  output logic                          coef_cnt,
  output logic                          data_load,
  output logic                          data_cnt,
  output logic                          mac_clr,
  output logic                          mac_en,
  output logic                          mac_last,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          busy
`ifdef CTRL_SEQ_STATS_EN
  ,
  output logic [15:0]                   stat_samples,
  output logic [15:0]                   stat_stalls
`endif
);

  localparam int DAW = DATA_ADDRESS_WIDTH;
  localparam int PW  = PHASE_WIDTH;
  localparam int TW  = TAPS_WIDTH;

  // After the final tap: wait out the MAC pipeline, or go straight to OUT
  // when there is no pipeline to drain.
  localparam state_t     POST_RUN       = (MAC_LATENCY > 0) ? S_DRAIN : S_OUT;
  localparam logic       POST_RUN_VALID = (MAC_LATENCY == 0);
  localparam logic [2:0] DRAIN_INIT     = (MAC_LATENCY > 0) ? 3'(MAC_LATENCY - 1) : 3'd0;

  state_t           state;
  logic [PW-1:0]    phase_q;
  logic [TW-1:0]    taps_q;
  logic [DAW-1:0]   base_q;
  logic [2:0]       drain_cnt;
  logic             tap_last;
  logic [PW+TW-1:0] prod;
  logic [DAW-1:0]   ptr_next;

  // Full-width product, then truncated to the address width so the
  // pointer wraps modulo the coefficient address space.
  assign prod     = {{TW{1'b0}}, phase_q} * {{PW{1'b0}}, taps_q};
  assign ptr_next = base_q + DAW'(prod);

  ctrl_seq_tapcnt #(.TAPS_WIDTH(TW)) u_tapcnt (
    .clk  (clk),
    .clr  (clr),
    .load (state == S_LOAD),
    .dec  (state == S_RUN),
    .taps (taps_q),
    .last (tap_last)
  );

  // Both terms are flop outputs; tap_last is only ever high during RUN.
  assign mac_last = mac_en & tap_last;

  // Strobes are registered: each is set on the edge that enters the state
  // that owns it and cleared on the edge that leaves it.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      phase_q     <= '0;
      taps_q      <= '0;
      base_q      <= '0;
      drain_cnt   <= '0;
      coef_ptr    <= '0;
      phase_ready <= 1'b1;
      busy        <= 1'b0;
      coef_load   <= 1'b0;
      data_load   <= 1'b0;
      mac_clr     <= 1'b0;
      coef_cnt    <= 1'b0;
      data_cnt    <= 1'b0;
      mac_en      <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (phase_valid) begin
            phase_q     <= phase_idx;
            taps_q      <= taps_per_phase;
            base_q      <= coef_base;
            phase_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= S_CALC;
          end
        end
        S_CALC: begin
          coef_ptr  <= ptr_next;
          coef_load <= 1'b1;
          data_load <= 1'b1;
          mac_clr   <= 1'b1;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          coef_load <= 1'b0;
          data_load <= 1'b0;
          mac_clr   <= 1'b0;
          if (taps_q == '0) begin
            state     <= POST_RUN;
            res_valid <= POST_RUN_VALID;
            drain_cnt <= DRAIN_INIT;
          end else begin
            coef_cnt <= 1'b1;
            data_cnt <= 1'b1;
            mac_en   <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (tap_last) begin
            coef_cnt  <= 1'b0;
            data_cnt  <= 1'b0;
            mac_en    <= 1'b0;
            state     <= POST_RUN;
            res_valid <= POST_RUN_VALID;
            drain_cnt <= DRAIN_INIT;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            res_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            phase_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CTRL_SEQ_STATS_EN
  // Both counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (clr) begin
      stat_samples <= '0;
      stat_stalls  <= '0;
    end else if (state == S_OUT) begin
      if (res_ready) stat_samples <= stat_samples + 16'd1;
      else           stat_stalls  <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_mac_sequencer.sv
module tb_ctrl_mac_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        phase_valid;
  logic        phase_ready;
  logic [4:0]  phase_idx;
  logic [11:0] coef_base;
  logic [7:0]  taps_per_phase;
  logic [11:0] coef_ptr;
  logic        coef_load, coef_cnt, data_load, data_cnt;
  logic        mac_clr, mac_en, mac_last;
  logic        res_valid, res_ready, busy;
`ifdef CTRL_SEQ_STATS_EN
  logic [15:0] stat_samples, stat_stalls;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_mac_sequencer dut (
    .clk            (clk),
    .clr            (clr),
    .phase_valid    (phase_valid),
    .phase_ready    (phase_ready),
    .phase_idx      (phase_idx),
    .coef_base      (coef_base),
    .taps_per_phase (taps_per_phase),
    .coef_ptr       (coef_ptr),
    .coef_load      (coef_load),
    .coef_cnt       (coef_cnt),
    .data_load      (data_load),
    .data_cnt       (data_cnt),
    .mac_clr        (mac_clr),
    .mac_en         (mac_en),
    .mac_last       (mac_last),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .busy           (busy)
`ifdef CTRL_SEQ_STATS_EN
    ,
    .stat_samples   (stat_samples),
    .stat_stalls    (stat_stalls)
`endif
  );

  // Strobe invariants, checked every cycle.
  always @(negedge clk) begin
    total++;
    if ((coef_load && coef_cnt) || (data_load && data_cnt) ||
        (coef_load !== data_load) || (coef_cnt !== data_cnt) ||
        (mac_clr !== coef_load) || (mac_en !== coef_cnt) || (mac_last && !mac_en)) begin
      bad++;
      $display("FAIL strobe_invariant t=%0t got cl=%b dl=%b cc=%b dc=%b clr=%b en=%b last=%b",
               $time, coef_load, data_load, coef_cnt, data_cnt, mac_clr, mac_en, mac_last);
    end
  end

  // Drives one sample through and measures strobes relative to the accept
  // edge (k = cycles after accept). Config inputs are scrambled right after
  // accept so any use of un-latched values shows up.
  task automatic run_sample(input logic [4:0] ph, input logic [11:0] base,
                            input logic [7:0] tp, input int stall,
                            output int n_en, output int n_load, output int n_last,
                            output int last_k, output int res_k, output int res_len,
                            output int n_rdy, output logic [11:0] ptr);
    int  stalled;
    bit  done;
    int  w;
    n_en = 0; n_load = 0; n_last = 0; last_k = -1; res_k = -1; res_len = 0;
    n_rdy = 0; ptr = '0; stalled = 0; done = 0;
    @(negedge clk);
    phase_idx = ph; coef_base = base; taps_per_phase = tp;
    phase_valid = 1'b1; res_ready = (stall == 0);
    w = 0;
    while (!phase_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!phase_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got phase_ready=%b want 1", phase_ready);
      phase_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    phase_valid = 1'b0;
    phase_idx = ~ph; coef_base = ~base; taps_per_phase = tp + 8'd5;
    for (int k = 1; k <= 400 && !done; k++) begin
      @(negedge clk);
      if (mac_en) n_en++;
      if (mac_last) begin n_last++; last_k = k; end
      if (coef_load) begin n_load++; ptr = coef_ptr; end
      if (phase_ready) n_rdy++;
      if (res_valid) begin
        if (res_k < 0) res_k = k;
        res_len++;
        if (stalled < stall) begin res_ready = 1'b0; stalled++; end
        else begin res_ready = 1'b1; done = 1; end
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL result_timeout got no handshake want res_valid within 400 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; phase_valid = 1'b0; phase_idx = '0; coef_base = '0;
    taps_per_phase = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (phase_ready !== 1'b1) begin bad++; $display("FAIL reset_phase_ready got %b want 1", phase_ready); end
    total++;
    if (coef_ptr !== 12'h000) begin bad++; $display("FAIL reset_coef_ptr got %h want 000", coef_ptr); end
    total++;
    if ({coef_load, data_load, coef_cnt, data_cnt, mac_clr, mac_en, mac_last, res_valid, busy} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got %b want 000000000",
               {coef_load, data_load, coef_cnt, data_cnt, mac_clr, mac_en, mac_last, res_valid, busy});
    end
  endtask

  task automatic test_basic();
    int n_en, n_load, n_last, last_k, res_k, res_len, n_rdy;
    logic [11:0] ptr;
    run_sample(5'd3, 12'h100, 8'd16, 0, n_en, n_load, n_last, last_k, res_k, res_len, n_rdy, ptr);
    total++; if (ptr !== 12'h130) begin bad++; $display("FAIL basic_ptr got %h want 130", ptr); end
    total++; if (n_en != 16) begin bad++; $display("FAIL basic_mac_en got %0d want 16", n_en); end
    total++; if (n_last != 1 || last_k != 18) begin
      bad++; $display("FAIL basic_mac_last got n=%0d k=%0d want n=1 k=18", n_last, last_k); end
    total++; if (n_load != 1) begin bad++; $display("FAIL basic_load got %0d want 1", n_load); end
    total++; if (res_k != 21 || res_len != 1) begin
      bad++; $display("FAIL basic_res got k=%0d len=%0d want k=21 len=1", res_k, res_len); end
    @(negedge clk);
    total++; if (phase_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle got ready=%b busy=%b want 1 0", phase_ready, busy); end
  endtask

  task automatic test_zero_taps();
    int n_en, n_load, n_last, last_k, res_k, res_len, n_rdy;
    logic [11:0] ptr;
    run_sample(5'd7, 12'h100, 8'd0, 0, n_en, n_load, n_last, last_k, res_k, res_len, n_rdy, ptr);
    total++; if (n_load != 1 || ptr !== 12'h100) begin
      bad++; $display("FAIL zero_load got n=%0d ptr=%h want 1 100", n_load, ptr); end
    total++; if (n_en != 0 || n_last != 0) begin
      bad++; $display("FAIL zero_mac_en got en=%0d last=%0d want 0 0", n_en, n_last); end
    total++; if (res_k != 5) begin bad++; $display("FAIL zero_res got k=%0d want 5", res_k); end
  endtask

  task automatic test_stall();
    int n_en, n_load, n_last, last_k, res_k, res_len, n_rdy;
    logic [11:0] ptr;
    run_sample(5'd2, 12'h020, 8'd3, 10, n_en, n_load, n_last, last_k, res_k, res_len, n_rdy, ptr);
    total++; if (ptr !== 12'h026) begin bad++; $display("FAIL stall_ptr got %h want 026", ptr); end
    total++; if (res_k != 8 || res_len != 11) begin
      bad++; $display("FAIL stall_res got k=%0d len=%0d want k=8 len=11", res_k, res_len); end
    total++; if (n_rdy != 0) begin bad++; $display("FAIL stall_phase_ready got %0d ready cycles want 0", n_rdy); end
`ifdef CTRL_SEQ_STATS_EN
    total++; if (stat_samples !== 16'd3 || stat_stalls !== 16'd10) begin
      bad++; $display("FAIL stall_stats got samples=%0d stalls=%0d want 3 10", stat_samples, stat_stalls); end
`endif
    res_ready = 1'b1;
  endtask

  task automatic test_wrap();
    int n_en, n_load, n_last, last_k, res_k, res_len, n_rdy;
    logic [11:0] ptr;
    run_sample(5'd1, 12'hFF0, 8'd32, 0, n_en, n_load, n_last, last_k, res_k, res_len, n_rdy, ptr);
    total++; if (ptr !== 12'h010) begin bad++; $display("FAIL wrap_ptr got %h want 010", ptr); end
    total++; if (n_en != 32 || res_k != 37) begin
      bad++; $display("FAIL wrap_timing got en=%0d k=%0d want 32 37", n_en, res_k); end
  endtask

  task automatic test_clr_mid_run();
    int seen;
    @(negedge clk);
    phase_idx = 5'd3; coef_base = 12'h100; taps_per_phase = 8'd16;
    phase_valid = 1'b1; res_ready = 1'b1;
    total++; if (phase_ready !== 1'b1) begin bad++; $display("FAIL clr_pre_idle got %b want 1", phase_ready); end
    @(posedge clk);
    #1;
    phase_valid = 1'b0;
    repeat (7) @(negedge clk);
    total++; if (mac_en !== 1'b1) begin bad++; $display("FAIL clr_in_run got mac_en=%b want 1", mac_en); end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    total++;
    if (phase_ready !== 1'b1 || busy !== 1'b0 || coef_ptr !== 12'h000 ||
        {coef_load, coef_cnt, mac_clr, mac_en, mac_last, res_valid} !== 6'b0) begin
      bad++;
      $display("FAIL clr_idle got ready=%b busy=%b ptr=%h strobes=%b want 1 0 000 000000",
               phase_ready, busy, coef_ptr, {coef_load, coef_cnt, mac_clr, mac_en, mac_last, res_valid});
    end
`ifdef CTRL_SEQ_STATS_EN
    total++; if (stat_samples !== 16'd0 || stat_stalls !== 16'd0) begin
      bad++; $display("FAIL clr_stats got samples=%0d stalls=%0d want 0 0", stat_samples, stat_stalls); end
`endif
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || mac_en) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL clr_dropped got %0d active cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int n_res;
    int w;
    n_res = 0;
    @(negedge clk);
    phase_idx = 5'd1; coef_base = 12'h000; taps_per_phase = 8'd4;
    res_ready = 1'b1; phase_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (i > 0) @(negedge clk);
      if (phase_ready && phase_valid) acc.push_back(i);
      if (res_valid) n_res++;
    end
    phase_valid = 1'b0;
    total++; if (acc.size() != 5) begin bad++; $display("FAIL b2b_accepts got %0d want 5", acc.size()); end
    for (int j = 1; j < acc.size(); j++) begin
      total++;
      if (acc[j] - acc[j-1] != 10) begin
        bad++; $display("FAIL b2b_interval got %0d want 10", acc[j] - acc[j-1]); end
    end
    total++; if (n_res != 4) begin bad++; $display("FAIL b2b_results got %0d want 4", n_res); end
    w = 0;
    while (!phase_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    total++; if (phase_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain got ready=%b want 1", phase_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_taps();
    test_stall();
    test_wrap();
    test_clr_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
